// File: rtl/display_frame_capture.sv
// Capture side of the 74HC595-style LED-matrix stream: rebuilds the shift chain,
// latches rows into an 8-row frame buffer, and flags malformed latches.
// Optional statistics counters are built only when CAPTURE_STATS_EN is defined.
//
// state    | meaning
// S_IDLE   | no bits shifted since the last latch
// S_SHIFT  | bits are accumulating in the shift chain
// S_COMMIT | one cycle: validate the latched row and write it to the frame buffer
module display_frame_capture #(
  parameter int CHAIN_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLOCK,
  input  logic                  reset,
  input  logic                  SH_CP,
  input  logic                  ST_CP,
  input  logic                  DS,
  input  logic                  OE,
  input  logic [7:0]            KATOT,
  input  logic [2:0]            rd_row,
  output logic [CHAIN_BITS-1:0] rd_data,
  output logic [CHAIN_BITS-1:0] row_data,
  output logic [2:0]            row_idx,
  output logic                  row_valid,
  output logic                  frame_valid,
  output logic                  len_err,
  output logic                  katot_err,
  output logic [15:0]           frame_count,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  localparam logic [5:0] CHAIN_CNT = 6'(CHAIN_BITS);

  // All five stream inputs share one synchronizer so their alignment is kept.
  logic [SYNC_STAGES-1:0][11:0] sync_q, sync_d;
  logic [11:0]                  in_s;
  logic [1:0]                   hist_q, hist_d;
  logic                         sh_rise, st_rise, ds_s, oe_s;
  logic [7:0]                   katot_s;

  state_t                       state_q, state_d;
  logic [CHAIN_BITS-1:0]        shift_q, shift_d;
  logic [CHAIN_BITS-1:0]        storage_q, storage_d;
  logic [5:0]                   bit_cnt_q, bit_cnt_d;
  logic                         cap_oe_q, cap_oe_d;
  logic [7:0]                   cap_katot_q, cap_katot_d;
  logic [5:0]                   cap_cnt_q, cap_cnt_d;
  logic [7:0]                   rows_seen_q, rows_seen_d;
  logic [7:0][CHAIN_BITS-1:0]   frame_q, frame_d;
  logic [CHAIN_BITS-1:0]        rd_data_q, rd_data_d;
  logic [CHAIN_BITS-1:0]        row_data_q, row_data_d;
  logic [2:0]                   row_idx_q, row_idx_d;
  logic                         row_valid_q, row_valid_d;
  logic                         frame_valid_q, frame_valid_d;
  logic                         len_err_q, len_err_d;
  logic                         katot_err_q, katot_err_d;

  logic [3:0]                   zero_cnt;
  logic [2:0]                   row_w;
  logic                         katot_ok;
  logic [7:0]                   mask_set;

  always_comb begin
    sync_d[0] = {KATOT, OE, DS, ST_CP, SH_CP};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign in_s    = sync_q[SYNC_STAGES-1];
  assign hist_d  = in_s[1:0];
  assign sh_rise = in_s[0] & ~hist_q[0];
  assign st_rise = in_s[1] & ~hist_q[1];
  assign ds_s    = in_s[2];
  assign oe_s    = in_s[3];
  assign katot_s = in_s[11:4];

  always_comb begin
    zero_cnt = '0;
    row_w    = '0;
    for (int i = 0; i < 8; i++) begin
      if (!cap_katot_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        row_w    = 3'(i);
      end
    end
  end

  assign katot_ok = (zero_cnt == 4'd1);
  assign mask_set = rows_seen_q | (8'b1 << row_w);

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    storage_d     = storage_q;
    bit_cnt_d     = bit_cnt_q;
    cap_oe_d      = cap_oe_q;
    cap_katot_d   = cap_katot_q;
    cap_cnt_d     = cap_cnt_q;
    rows_seen_d   = rows_seen_q;
    frame_d       = frame_q;
    row_data_d    = row_data_q;
    row_idx_d     = row_idx_q;
    row_valid_d   = 1'b0;
    frame_valid_d = 1'b0;
    len_err_d     = 1'b0;
    katot_err_d   = 1'b0;
    rd_data_d     = frame_q[rd_row];

    if (sh_rise) begin
      shift_d   = {shift_q[CHAIN_BITS-2:0], ds_s};
      bit_cnt_d = (bit_cnt_q == 6'd63) ? 6'd63 : bit_cnt_q + 6'd1;
    end

    // The latch sees the pre-shift chain, like a real 595 on coincident edges.
    if (st_rise) begin
      storage_d   = shift_q;
      cap_oe_d    = oe_s;
      cap_katot_d = katot_s;
      cap_cnt_d   = bit_cnt_q;
      bit_cnt_d   = sh_rise ? 6'd1 : 6'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (sh_rise) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        state_d = S_SHIFT;
      end
      S_COMMIT: begin
        state_d = (bit_cnt_d != 6'd0) ? S_SHIFT : S_IDLE;
        if (!cap_oe_q) begin
          if (!katot_ok) begin
            katot_err_d = 1'b1;
          end else begin
            frame_d[row_w] = storage_q;
            row_data_d     = storage_q;
            row_idx_d      = row_w;
            row_valid_d    = 1'b1;
            len_err_d      = (cap_cnt_q != CHAIN_CNT);
            if (mask_set == 8'hFF) begin
              frame_valid_d = 1'b1;
              rows_seen_d   = 8'h00;
            end else begin
              rows_seen_d   = mask_set;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (st_rise) state_d = S_COMMIT;
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      sync_q        <= '0;
      hist_q        <= '0;
      state_q       <= S_IDLE;
      shift_q       <= '0;
      storage_q     <= '0;
      bit_cnt_q     <= '0;
      cap_oe_q      <= 1'b0;
      cap_katot_q   <= '0;
      cap_cnt_q     <= '0;
      rows_seen_q   <= '0;
      frame_q       <= '0;
      rd_data_q     <= '0;
      row_data_q    <= '0;
      row_idx_q     <= '0;
      row_valid_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      len_err_q     <= 1'b0;
      katot_err_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      hist_q        <= hist_d;
      state_q       <= state_d;
      shift_q       <= shift_d;
      storage_q     <= storage_d;
      bit_cnt_q     <= bit_cnt_d;
      cap_oe_q      <= cap_oe_d;
      cap_katot_q   <= cap_katot_d;
      cap_cnt_q     <= cap_cnt_d;
      rows_seen_q   <= rows_seen_d;
      frame_q       <= frame_d;
      rd_data_q     <= rd_data_d;
      row_data_q    <= row_data_d;
      row_idx_q     <= row_idx_d;
      row_valid_q   <= row_valid_d;
      frame_valid_q <= frame_valid_d;
      len_err_q     <= len_err_d;
      katot_err_q   <= katot_err_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign row_data    = row_data_q;
  assign row_idx     = row_idx_q;
  assign row_valid   = row_valid_q;
  assign frame_valid = frame_valid_q;
  assign len_err     = len_err_q;
  assign katot_err   = katot_err_q;

`ifdef CAPTURE_STATS_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  err_count_q, err_count_d;

  // Both error flags in one cycle count as a single event.
  always_comb begin
    frame_count_d = frame_valid_d ? frame_count_q + 16'd1 : frame_count_q;
    err_count_d   = err_count_q;
    if ((len_err_d || katot_err_d) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;
`else
  assign frame_count = 16'h0000;
  assign err_count   = 8'h00;
`endif

endmodule
